// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and sizing constants for the Booth multiplier
package booth_pkg;
  localparam int N = 8;
  localparam int ITER = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/eight_bit_as.sv
// eight_bit_as: 8-bit two's-complement adder/subtractor (op=0 add, op=1 subtract) with overflow
module eight_bit_as (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       op,
  output logic [7:0] sum,
  output logic       ovf
);
  logic [7:0] yb;
  logic [7:0] lo;
  logic [1:0] hi;
  always_comb begin
    yb = y ^ {8{op}};
    lo = {1'b0, x[6:0]} + {1'b0, yb[6:0]} + {7'd0, op};
    hi = {1'b0, x[7]} + {1'b0, yb[7]} + {1'b0, lo[7]};
    sum = {hi[0], lo[6:0]};
    ovf = lo[7] ^ hi[1];
  end
endmodule

// File: rtl/booth_mult8.sv
// booth_mult8: sequential radix-2 Booth signed multiplier, one iteration per clock
module booth_mult8 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);
  import booth_pkg::*;
  state_t state, nxt;
  logic [N-1:0] m, acc, q, sum, acc_n;
  logic [3:0] cnt;
  logic q_1, ovf, sgn, act, accept, last;
  eight_bit_as u_as (.x(acc), .y(m), .op(q[0]), .sum(sum), .ovf(ovf));
  always_comb begin
    accept = start && state != CALC;
    last = cnt == 4'(ITER - 1);
    act = q[0] ^ q_1;
    acc_n = act ? sum : acc;
    // overflow-corrected sign keeps the shift exact when A-M wraps (M=-128)
    sgn = act ? sum[N-1] ^ ovf : acc[N-1];
    nxt = accept ? CALC : (state == CALC ? (last ? DONE : CALC) : IDLE);
    busy = state == CALC;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      acc <= '0;
      q <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
      product <= '0;
    end else if (accept) begin
      m <= a;
      acc <= '0;
      q <= b;
      q_1 <= 1'b0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= {sgn, acc_n[N-1:1]};
      q <= {acc_n[0], q[N-1:1]};
      q_1 <= q[0];
      cnt <= cnt + 4'd1;
      if (last) product <= {sgn, acc_n, q[N-1:1]};
    end
  end
endmodule

// File: tb/tb_booth_mult8.sv
// tb_booth_mult8: randomized self-checking bench against a plain signed-multiply model
module tb_booth_mult8;
  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] a, b;
  logic [15:0] product;
  logic busy, done;
  int n_chk = 0;
  int n_err = 0;

  booth_mult8 dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                   .product(product), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic signed [7:0] x, input logic signed [7:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit repulse);
    int cyc, bc;
    logic [15:0] exp;
    exp = model(x, y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; bc = 0;
    while (!done && cyc < 20) begin
      bc += int'(busy);
      a = 8'($urandom); b = 8'($urandom);
      if (repulse) start = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_cycles", bc, 8);
    chk("latency", cyc, 8);
    chk("product", {16'd0, product}, {16'd0, exp});
    @(negedge clk);
    chk("done_pulse_1cyc", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("product_hold", {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] xs[3];
    logic [7:0] ys[3];
    int cyc, dn;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd3, 8'd5, 1'b0);
    chk("3x5_const", {16'd0, product}, 32'h000F);
    do_op(8'h80, 8'h80, 1'b0);
    chk("m128xm128_const", {16'd0, product}, 32'h4000);
    do_op(8'h80, 8'd127, 1'b0);
    chk("m128x127_const", {16'd0, product}, 32'hC080);
    do_op(8'hFF, 8'd127, 1'b0);
    chk("m1x127_const", {16'd0, product}, 32'hFF81);
    do_op(8'd0, 8'hB3, 1'b0);
    chk("0xm77_const", {16'd0, product}, 32'h0000);
    do_op(8'd37, 8'hC9, 1'b1);
    for (int i = 0; i < 30; i++) do_op(8'($urandom), 8'($urandom), i[0]);
    do_op(8'd127, 8'h80, 1'b0);
    do_op(8'h80, 8'd1, 1'b0);
    // abort mid-CALC: outputs must clear without waiting for a clock edge
    do_op(8'd11, 8'd13, 1'b0);
    @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_product", {16'd0, product}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    dn = 0;
    repeat (3) @(negedge clk) dn += int'(done);
    rst = 1'b0;
    repeat (12) @(negedge clk) dn += int'(done);
    chk("no_done_after_abort", dn, 0);
    do_op(8'd7, 8'hFA, 1'b0);
    chk("7xm6_const", {16'd0, product}, 32'hFFD6);
    // start held high: each op re-accepted from DONE with no idle gap
    xs = '{8'd2, 8'hFD, 8'd100};
    ys = '{8'd2, 8'd4, 8'd100};
    @(negedge clk);
    a = xs[0]; b = ys[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 20);
      chk("b2b_period", cyc, 9);
      chk("b2b_product", {16'd0, product}, {16'd0, model(xs[k], ys[k])});
      if (k < 2) begin
        a = xs[k+1]; b = ys[k+1];
      end else start = 1'b0;
    end
    chk("b2b_last_const", {16'd0, product}, 32'h2710);
    @(negedge clk);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/booth_mult8.md
BOOTH_MULT8 -- requirements
Module: booth_mult8

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to begin a multiply; sampled on rising clk.
REQ-004 SHALL have port: a  input  8  multiplicand, two's complement; captured only when start is accepted.
REQ-005 SHALL have port: b  input  8  multiplier, two's complement; captured only when start is accepted.
REQ-006 SHALL have port: product  output  16  signed product register; holds the last result until overwritten.
REQ-007 SHALL have port: busy  output  1  high while iterating (state CALC).
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking product valid and newly updated.
REQ-009 SHALL have parameter: N, default 8, operand width; only N=8 is required to work.

Function
REQ-010 SHALL implement radix-2 Booth signed multiply: regs M[7:0], A[7:0], Q[7:0], Q_1, cnt[3:0], state.
REQ-011 SHALL have three states: IDLE, CALC, DONE.
REQ-012 SHALL accept start in IDLE or DONE only; on acceptance load M=a, Q=b, A=0, Q_1=0, cnt=0, next state CALC.
REQ-013 SHALL ignore start while in CALC, with no effect on registers or outputs.
REQ-014 SHALL perform one iteration per CALC cycle. {Q[0],Q_1}=01 -> A+M. 10 -> A-M. 00/11 -> A unchanged.
REQ-015 SHALL form each add/subtract as an 8-bit two's-complement operation producing sum[7:0] and an overflow flag (carry into MSB XOR carry out).
REQ-016 SHALL arithmetic-shift-right {A',Q,Q_1} each iteration; the bit shifted into A[7] SHALL be sum[7] XOR overflow (true sign), and SHALL be A'[7] when no add/sub occurs.
REQ-017 SHALL increment cnt each iteration. The 8th iteration (cnt=7) SHALL latch product={A,Q} post-shift and move to DONE.
REQ-018 SHALL assert done for exactly the one cycle spent in DONE, then go to IDLE unless start is accepted in that cycle.
REQ-019 SHALL give latency: done high in the cycle following the 8th rising edge after the edge that accepted start; busy high for exactly 8 cycles.
REQ-020 SHALL support back-to-back operation: start accepted in DONE reloads and re-enters CALC with no IDLE cycle.
REQ-021 SHALL produce correct results for all 65536 operand pairs, including a=-128 (-M overflow) and -128*-128=+16384.
REQ-022 SHALL keep product stable outside the latch edge; a and b changes during CALC SHALL have no effect.

Reset
REQ-023 SHALL, on rst high, immediately force state=IDLE, product=0, busy=0, done=0, and A, Q, Q_1, M, cnt to 0, regardless of clk.
REQ-024 SHALL abort any in-progress multiply on reset (no done pulse). The first start after rst deasserts SHALL be honoured normally.

Structure
REQ-025 SHALL place state encodings (IDLE=0, CALC=1, DONE=2, 2-bit) and the constants N=8 and ITER=8 in shared package booth_pkg.
REQ-026 SHALL instantiate one eight_bit_as adder-subtractor for the add/subtract. Opcode SHALL be 0 for add and 1 for subtract; its overflow output feeds REQ-016.
REQ-027 SHALL keep the FSM, shift registers and counter in booth_mult8 itself, with no further sub-modules.

Verification
REQ-028 SHALL check: a=3, b=5, start 1 cycle -> busy 8 cycles, then done pulse with product=16'h000F.
REQ-029 SHALL check: a=-128, b=-128 -> product=16'h4000. a=-128, b=127 -> product=16'hC080.
REQ-030 SHALL check: a=-1, b=127 -> 16'hFF81. a=0, b=-77 -> 16'h0000. Each result arrives with exactly one done pulse.
REQ-031 SHALL check: start re-pulsed with new a/b at CALC cycle 3 -> ignored, result matches the first operands, timing unchanged.
REQ-032 SHALL check: rst asserted mid-CALC (cycle 5) -> outputs 0 asynchronously, no done. A new start for 7*-6 -> 16'hFFD6.
REQ-033 SHALL check: start held high continuously for 3 ops (2*2, -3*4, 100*100) -> done every 9 cycles with products 16'h0004, 16'hFFF4, 16'h2710.
